// File: rtl/me_sequencer_if.sv
//==============================================================================
// Module      : me_sequencer_if
// Description : Control/address bundle between the motion-estimation frame
//               sequencer and its host, memories, PE array and comparator.
//               master : host side (drives start/abort, observes the rest)
//               slave  : sequencer side (observes start/abort, drives the rest)
//               start/abort       frame request and synchronous abort
//               AddressR/S1/S2    reference and search memory addresses
//               S1S2mux/NewDist   per-PE search-half select and restart strobe
//               PEready/Vector*   per-PE finished strobe and its motion vector
//               CompStart         comparator enable
//               busy/done         status and one-cycle completion pulse
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface me_sequencer_if;
    logic        start;
    logic        abort;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1;
    logic [9:0]  AddressS2;
    logic [15:0] S1S2mux;
    logic [15:0] NewDist;
    logic [15:0] PEready;
    logic        CompStart;
    logic [3:0]  VectorX;
    logic [3:0]  VectorY;
    logic        busy;
    logic        done;

    modport master (
        output start, abort,
        input  AddressR, AddressS1, AddressS2, S1S2mux, NewDist, PEready,
        input  CompStart, VectorX, VectorY, busy, done
    );

    modport slave (
        input  start, abort,
        output AddressR, AddressS1, AddressS2, S1S2mux, NewDist, PEready,
        output CompStart, VectorX, VectorY, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/me_sequencer.sv
//==============================================================================
// Module      : me_sequencer
// Description : Frame sequencer for the 16-PE motion-estimation array. Walks
//               the 16 vertical search offsets of a 32x32 window against a
//               16x16 reference block (256 cycles per pass), then drains the
//               last pass out of the array and pulses done.
//               clock : system clock, rising edge
//               reset : asynchronous, active-high
//               bus   : me_sequencer_if.slave (start/abort in, addresses,
//                       per-PE strobes, vectors and status out)
//               All outputs decode from registered state only.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module me_sequencer (
    input  wire logic     clock,
    input  wire logic     reset,
    me_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  vy_q, vy_d;     // vertical search offset (pass number)
    logic [7:0]  c_q, c_d;       // cycle within pass / drain slot

    //--------------------------------------------------------------------------
    // State and counter registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vy_q    <= 4'd0;
            c_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            vy_q    <= vy_d;
            c_q     <= c_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vy_d    = vy_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                vy_d = 4'd0;
                c_d  = 8'd0;
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    vy_d    = 4'd0;
                    c_d     = 8'd0;
                end else begin
                    c_d = c_q + 8'd1;   // wraps to 0 at the end of a pass
                    if (c_q == 8'hFF) begin
                        vy_d = vy_q + 4'd1;
                        if (vy_q == 4'hF) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    vy_d    = 4'd0;
                    c_d     = 8'd0;
                end else if (c_q == 8'd15) begin
                    state_d = S_DONE;
                    c_d     = 8'd0;
                end else begin
                    c_d = c_q + 8'd1;
                end
            end
            default: begin
                // DONE always returns to IDLE; abort changes nothing here
                state_d = S_IDLE;
                vy_d    = 4'd0;
                c_d     = 8'd0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output decode
    //--------------------------------------------------------------------------
    logic [9:0]  row;           // search-window row = vy + block row
    logic [7:0]  addr_r;
    logic [9:0]  addr_s1;
    logic [9:0]  addr_s2;
    logic [15:0] s1s2_mux;
    logic [15:0] new_dist;
    logic [15:0] pe_ready;
    logic        comp_start;
    logic [3:0]  vec_x;
    logic [3:0]  vec_y;
    logic        busy;
    logic        done;

    always_comb begin
        row        = 10'd0;
        addr_r     = 8'd0;
        addr_s1    = 10'd0;
        addr_s2    = 10'd0;
        s1s2_mux   = 16'd0;
        new_dist   = 16'd0;
        pe_ready   = 16'd0;
        comp_start = 1'b0;
        vec_x      = 4'd0;
        vec_y      = 4'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_RUN: begin
                addr_r  = c_q;
                row     = {6'd0, vy_q} + {6'd0, c_q[7:4]};
                // row <= 30, so row*32 + col never exceeds 975
                addr_s1 = {row[4:0], 5'd0} + {6'd0, c_q[3:0]};
                addr_s2 = addr_s1 + 10'd16;
                for (int i = 0; i < 16; i++) begin
                    s1s2_mux[i] = (c_q[3:0] >= i[3:0]);
                end
                if (c_q[7:4] == 4'd0) begin
                    new_dist[c_q[3:0]] = 1'b1;
                    // PE i reports the previous pass as it restarts
                    if (vy_q != 4'd0) begin
                        pe_ready[c_q[3:0]] = 1'b1;
                        vec_x = {~c_q[3], c_q[2:0]};   // i - 8
                        vec_y = vy_q + 4'd7;           // (vy - 1) - 8
                    end
                end
                comp_start = 1'b1;
                busy       = 1'b1;
            end
            S_DRAIN: begin
                pe_ready[c_q[3:0]] = 1'b1;
                vec_x      = {~c_q[3], c_q[2:0]};
                vec_y      = 4'd7;                     // last pass: 15 - 8
                comp_start = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                comp_start = 1'b1;
                done       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.AddressR  = addr_r;
    assign bus.AddressS1 = addr_s1;
    assign bus.AddressS2 = addr_s2;
    assign bus.S1S2mux   = s1s2_mux;
    assign bus.NewDist   = new_dist;
    assign bus.PEready   = pe_ready;
    assign bus.CompStart = comp_start;
    assign bus.VectorX   = vec_x;
    assign bus.VectorY   = vec_y;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

`default_nettype wire

// File: doc/me_sequencer.md
# me_sequencer

Frame-level sequencer for the 16-PE motion-estimation array. On a start request it walks the 16 vertical search offsets of the 32x32 search window against the 16x16 reference block. Per cycle it generates the R/S1/S2 memory addresses, the per-PE S1/S2 select and new-distortion strobes, and the per-PE ready strobes and motion vectors consumed by the comparator. It flushes the array after the last pass and signals completion with a done pulse.

## Interface
Parameters: none; array is fixed at 16 PEs, 16x16 block, 32x32 window.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next edge, no done
- AddressR  out  8  reference memory address
- AddressS1  out  10  search memory address, left half
- AddressS2  out  10  search memory address, right half
- S1S2mux  out  16  per-PE select: 1 = S1, 0 = S2
- NewDist  out  16  per-PE strobe: restart accumulation
- PEready  out  16  per-PE strobe: accumulator holds a finished distortion
- CompStart  out  1  comparator enable; 0 resets BestDist to 8'hff
- VectorX  out  4  two's-complement x offset of the ready PE
- VectorY  out  4  two's-complement y offset of the ready PE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse

## Operation
- State register: IDLE, RUN, DRAIN, DONE. Counters: pass vy[3:0] and cycle c[7:0].
- All outputs decode from the state and counter registers only. There is no combinational path from start/abort to any output.
- IDLE:
  - All outputs 0.
  - start=1 → RUN with vy=0, c=0.
- RUN:
  - c increments every cycle.
  - At c=255, c wraps to 0 and vy increments.
  - At c=255 with vy=15 → DRAIN, c=0.
- RUN outputs:
  - AddressR = c.
  - AddressS1 = (vy + c[7:4])*32 + c[3:0]. Compute at 10 bits; the maximum is 30*32+15 = 975, so there is no wrap.
  - AddressS2 = AddressS1 + 16.
  - S1S2mux[i] = (c[3:0] >= i).
  - NewDist[i] = (c == i).
  - PEready[i] = (c == i) && (vy != 0). This is the previous pass's result, read the same cycle its accumulator restarts.
  - CompStart = 1.
- DRAIN:
  - c counts 0..15; at c=15 → DONE.
  - Address outputs, S1S2mux and NewDist are 0.
  - PEready[i] = (c == i); CompStart = 1.
- DONE: one cycle with done=1, CompStart=1, all strobes 0; then → IDLE.
- Vector outputs:
  - When PEready[i]=1: VectorX = i − 8.
  - VectorY = (vy − 1) − 8 in RUN, and 15 − 8 = 7 in DRAIN.
  - Otherwise both are 0.
- At most one PEready bit is set in any cycle. NewDist is one-hot or zero.
- start while busy or in DONE: ignored.
- abort in RUN, DRAIN or DONE: next state IDLE, counters cleared, no done pulse. abort in IDLE: no effect. abort and start together in IDLE: abort wins, stay IDLE.

## Timing
- Reset (asynchronous, any state): state=IDLE, vy=0, c=0. Every output, including busy and done, is 0 while reset is high and after release.
- Edge E0 samples start=1. Cycle 0 of RUN (c=0, vy=0) follows E0.
- RUN lasts 4096 cycles and DRAIN 16 cycles. done is high exactly in cycle 4112 after E0, and IDLE follows at cycle 4113.
- A new start is accepted at the earliest one cycle after the done pulse (IDLE sampling).
- Memory and PE pipeline latencies are absorbed by the array. The sequencer issues AddressR/AddressS* and strobes in the same cycle, with no internal delay.
- Per frame: 16*16 = 256 PEready pulses in total; 240 in RUN (passes 1..15) and 16 in DRAIN.

## Test plan
- Reset mid-RUN: assert reset at cycle 1000 → all outputs 0 immediately. After release, stays IDLE until start.
- Nominal frame: pulse start → busy=1 at cycle 0. At cycle 256+5: PEready=16'h0020, VectorX=4'hD (−3), VectorY=4'h8 (−8), AddressS1=32+5=37, AddressS2=53. done=1 only at cycle 4112.
- Address/mux check at vy=15, c=255: AddressR=255, AddressS1=975, AddressS2=991, S1S2mux=16'hFFFF, NewDist=0. At c=3: S1S2mux=16'h000F, NewDist=16'h0008.
- DRAIN: cycles 4096..4111 give PEready one-hot walking bit 0..15 with VectorY=4'h7 and VectorX from 4'h8 to 4'h7. Address outputs are 0 throughout.
- Abort at cycle 2000 → IDLE next cycle, busy=0, CompStart=0, no done. A start two cycles later runs a full 4113-cycle frame.
- start held high through the whole frame → ignored while busy. A second frame begins the cycle after DONE; VectorY pulses on the first pass are absent (vy=0).
